// File: rtl/fill_fifo_fsm.sv
// Pixel FIFO refill sequencer: turns hsync/vsync/half_full events into
// one-cycle DDR read requests, each for a chunk of the current display line.
module fill_fifo_fsm #(
    parameter int CHUNK_WORDS = 64
) (
    input  logic        Bus2IP_Clk,
    input  logic        reset_fill_fifo,
    input  logic        start_fill_fifo,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        half_full,
    input  logic [31:0] FRAME_BASE_ADDR,
    input  logic [31:0] LINE_STRIDE,
    input  logic [31:0] NUM_PIXELS_PER_LINE,
    input  logic [31:0] NUM_BYTES_PER_PIXEL,
    output logic [31:0] ddr_addr_to_read,
    output logic        go_fill_fifo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LINE_END
    } state_t;

    state_t      state, state_next;
    logic [31:0] line_base, line_base_next;
    logic [31:0] chunk_off, chunk_off_next;
    logic [31:0] addr_next;
    logic        go_next;

    logic [31:0] chunk_bytes;
    logic [31:0] line_bytes;
    logic [31:0] chunk_off_inc;
    logic [31:0] stride_base;

    // Byte geometry is recomputed from the live inputs, so a mid-frame change
    // lands at the next request that uses it.
    assign chunk_bytes   = 32'(CHUNK_WORDS) * NUM_BYTES_PER_PIXEL;
    assign line_bytes    = NUM_PIXELS_PER_LINE * NUM_BYTES_PER_PIXEL;
    assign chunk_off_inc = chunk_off + chunk_bytes;
    assign stride_base   = line_base + LINE_STRIDE;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next     = state;
        line_base_next = line_base;
        chunk_off_next = chunk_off;
        addr_next      = ddr_addr_to_read;

        if (!start_fill_fifo) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    line_base_next = FRAME_BASE_ADDR;
                    chunk_off_next = '0;
                    addr_next      = FRAME_BASE_ADDR;
                    state_next     = S_REQ;
                end
                S_REQ, S_WAIT: begin
                    state_next = S_WAIT;
                    if (vsync) begin
                        line_base_next = FRAME_BASE_ADDR;
                        chunk_off_next = '0;
                        addr_next      = FRAME_BASE_ADDR;
                        state_next     = S_REQ;
                    end else if (hsync) begin
                        line_base_next = stride_base;
                        chunk_off_next = '0;
                        addr_next      = stride_base;
                        state_next     = S_REQ;
                    end else if (half_full) begin
                        // The last chunk of the line is already in flight:
                        // park until the display moves to the next line.
                        if (chunk_off_inc < line_bytes) begin
                            chunk_off_next = chunk_off_inc;
                            addr_next      = line_base + chunk_off_inc;
                            state_next     = S_REQ;
                        end else begin
                            state_next = S_LINE_END;
                        end
                    end
                end
                S_LINE_END: begin
                    if (vsync) begin
                        line_base_next = FRAME_BASE_ADDR;
                        chunk_off_next = '0;
                        addr_next      = FRAME_BASE_ADDR;
                        state_next     = S_REQ;
                    end else if (hsync) begin
                        line_base_next = stride_base;
                        chunk_off_next = '0;
                        addr_next      = stride_base;
                        state_next     = S_REQ;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        go_next = (state_next == S_REQ);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge Bus2IP_Clk or posedge reset_fill_fifo) begin
        if (reset_fill_fifo) begin
            state            <= S_IDLE;
            line_base        <= '0;
            chunk_off        <= '0;
            ddr_addr_to_read <= '0;
            go_fill_fifo     <= 1'b0;
        end else begin
            state            <= state_next;
            line_base        <= line_base_next;
            chunk_off        <= chunk_off_next;
            ddr_addr_to_read <= addr_next;
            go_fill_fifo     <= go_next;
        end
    end

endmodule

// File: tb/tb_fill_fifo_fsm.sv
// Self-checking bench for fill_fifo_fsm: per-cycle vector table, a request
// scoreboard fed at drive time, and hand sequences for reset/parameter cases.
module tb_fill_fifo_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic        hsync;
    logic        vsync;
    logic        half_full;
    logic [31:0] frame_base;
    logic [31:0] line_stride;
    logic [31:0] num_pixels;
    logic [31:0] bytes_per_pixel;
    logic [31:0] ddr_addr;
    logic        go;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb[$];

    typedef struct {
        logic        start;
        logic        hsync;
        logic        vsync;
        logic        half_full;
        logic        exp_go;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    fill_fifo_fsm #(.CHUNK_WORDS(64)) dut (
        .Bus2IP_Clk          (clk),
        .reset_fill_fifo     (rst),
        .start_fill_fifo     (start),
        .hsync               (hsync),
        .vsync               (vsync),
        .half_full           (half_full),
        .FRAME_BASE_ADDR     (frame_base),
        .LINE_STRIDE         (line_stride),
        .NUM_PIXELS_PER_LINE (num_pixels),
        .NUM_BYTES_PER_PIXEL (bytes_per_pixel),
        .ddr_addr_to_read    (ddr_addr),
        .go_fill_fifo        (go)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at a negedge, then check outputs at the next negedge.
    task automatic step(input vec_t v, input string name);
        start     = v.start;
        hsync     = v.hsync;
        vsync     = v.vsync;
        half_full = v.half_full;
        if (v.exp_go) sb.push_back(v.exp_addr);
        @(posedge clk);
        @(negedge clk);
        check({name, ".go"}, {31'd0, go}, {31'd0, v.exp_go});
        check({name, ".addr"}, ddr_addr, v.exp_addr);
    endtask

    // Scoreboard: every observed strobe must match the oldest expected request.
    always @(negedge clk) begin
        if (!rst && go) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_strobe: got strobe at addr %h expected none", ddr_addr);
            end else begin
                check("sb_addr", ddr_addr, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // start hs vs hf go addr
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000}); // idle after reset
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000}); // start
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0100});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0100});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0200});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0200});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0300});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0300});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0300}); // line exhausted
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0300}); // ignored in LINE_END
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_4000}); // hsync
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_4000});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_4100});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_4100});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_4200});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_4200});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_4300});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_4300});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_8000}); // hsync from WAIT
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_8000});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000}); // vsync
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0000}); // all events: vsync wins
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0100});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0200}); // event while in REQ
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0200});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0200}); // drop start
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0200}); // events ignored
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000}); // restart at base
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000});

        rst             = 1'b1;
        start           = 1'b0;
        hsync           = 1'b0;
        vsync           = 1'b0;
        half_full       = 1'b0;
        frame_base      = 32'h8000_0000;
        line_stride     = 32'h0000_4000;
        num_pixels      = 32'd256;
        bytes_per_pixel = 32'd4;

        #1;
        check("reset.go", {31'd0, go}, 32'd0);
        check("reset.addr", ddr_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec[%0d]", i));
        end

        // Asynchronous reset while a strobe is high, mid-line.
        half_full = 1'b1;
        @(posedge clk);
        #1;
        half_full = 1'b0;
        check("pre_rst.go", {31'd0, go}, 32'd1);
        check("pre_rst.addr", ddr_addr, 32'h8000_0100);
        rst = 1'b1;
        #1;
        check("async_rst.go", {31'd0, go}, 32'd0);
        check("async_rst.addr", ddr_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000}, "post_rst");
        step('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000}, "post_rst_idle");

        // Parameter inputs changed mid-frame take effect at their next use.
        line_stride = 32'h0000_8000;
        step('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_8000}, "new_stride");
        step('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_8000}, "new_stride_idle");
        frame_base = 32'h1000_0000;
        step('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0000}, "new_base");
        bytes_per_pixel = 32'd2;
        step('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0080}, "new_bpp");
        step('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0080}, "new_bpp_idle");

        @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
